// File: rtl/pe_inst_sequencer_pkg.sv
// Shared definitions for the PE instruction fetch sequencer.
// FSM state encodings shared by the top and any debug/trace logic.
package pe_inst_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/pe_inst_sequencer_wrap_counter.sv
// Up-counter with enable and explicit wrap at a terminal value (compared one bit wider than the count).
// Registered count, combinational wrap pulse; holds while en is low.
module wrap_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic [W:0]   term,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic at_term;

    // The extra term bit lets a terminal of (1<<W)-1 be reached without relying on overflow.
    assign at_term = ({1'b0, cnt} == term);
    assign wrap    = en & at_term;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_term ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/pe_inst_sequencer.sv
// Per-PE instruction fetch sequencer driving the instruction ROM address and enable.
// Fetch-to-instValid 1 cycle; stall freezes PC, iteration, state and flags (noStall is combinational).
module pe_inst_sequencer
    import pe_inst_sequencer_pkg::*;
#(
    parameter int addrLen = 5,
    parameter int iterLen = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addrLen:0]   progLen,
    input  logic [iterLen-1:0] numIter,
    input  logic               stall,
    output logic [addrLen-1:0] rdAddr,
    output logic               noStall,
    output logic               instValid,
    output logic               lastInst,
    output logic [iterLen-1:0] iterIdx,
    output logic               busy,
    output logic               done
);

    logic [1:0]         state;
    logic [addrLen:0]   prog_len_q;
    logic [iterLen-1:0] num_iter_q;
    logic               accept;
    logic               fetch_fire;
    logic               pc_wrap;
    logic               last_issue;
    logic [addrLen:0]   pc_term;
    logic [iterLen:0]   iter_term;

    assign accept     = (state == ST_IDLE) && start;
    assign fetch_fire = (state == ST_FETCH) && !stall;
    assign pc_term    = prog_len_q - (addrLen + 1)'(1);
    assign iter_term  = {1'b0, num_iter_q - iterLen'(1)};
    assign noStall    = ~stall;
    assign busy       = (state != ST_IDLE);

    wrap_counter #(.W(addrLen)) u_pc (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (fetch_fire),
        .term  (pc_term),
        .cnt   (rdAddr),
        .wrap  (pc_wrap)
    );

    // The iteration counter only advances on a PC wrap, so its wrap marks the final issue.
    wrap_counter #(.W(iterLen)) u_iter (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (pc_wrap),
        .term  (iter_term),
        .cnt   (iterIdx),
        .wrap  (last_issue)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            prog_len_q <= '0;
            num_iter_q <= '0;
            instValid  <= 1'b0;
            lastInst   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        prog_len_q <= progLen;
                        num_iter_q <= numIter;
                        if (progLen == '0 || numIter == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (last_issue) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Flags track the ROM's registered dataOut, which also holds under stall.
            if (!stall) begin
                instValid <= (state == ST_FETCH);
                lastInst  <= last_issue;
            end
        end
    end

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Directed, table-driven bench for pe_inst_sequencer: one vector per clock cycle.
module tb_pe_inst_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  progLen;
    logic [15:0] numIter;
    logic        stall;
    logic [4:0]  rdAddr;
    logic        noStall;
    logic        instValid;
    logic        lastInst;
    logic [15:0] iterIdx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        start;
        logic        stall;
        logic        rst;
        logic [5:0]  prog;
        logic [15:0] iter;
        logic [4:0]  e_addr;
        logic        e_iv;
        logic        e_li;
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_idx;
    } vec_t;

    vec_t        tbl[$];
    logic [5:0]  cur_prog;
    logic [15:0] cur_iter;

    pe_inst_sequencer #(.addrLen(5), .iterLen(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .progLen   (progLen),
        .numIter   (numIter),
        .stall     (stall),
        .rdAddr    (rdAddr),
        .noStall   (noStall),
        .instValid (instValid),
        .lastInst  (lastInst),
        .iterIdx   (iterIdx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic add(input int st, input int sl, input int rs, input int addr,
                       input int iv, input int li, input int bsy, input int dn, input int idx);
        vec_t v;
        v.start  = st[0];
        v.stall  = sl[0];
        v.rst    = rs[0];
        v.prog   = cur_prog;
        v.iter   = cur_iter;
        v.e_addr = addr[4:0];
        v.e_iv   = iv[0];
        v.e_li   = li[0];
        v.e_busy = bsy[0];
        v.e_done = dn[0];
        v.e_idx  = idx[15:0];
        tbl.push_back(v);
    endtask

    // Called at posedge+1; each entry drives one cycle and checks that cycle's outputs.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            start   = tbl[i].start;
            stall   = tbl[i].stall;
            reset   = tbl[i].rst;
            progLen = tbl[i].prog;
            numIter = tbl[i].iter;
            #1;
            chk({tag, ".rdAddr"},    i, int'(rdAddr),    int'(tbl[i].e_addr));
            chk({tag, ".instValid"}, i, int'(instValid), int'(tbl[i].e_iv));
            chk({tag, ".lastInst"},  i, int'(lastInst),  int'(tbl[i].e_li));
            chk({tag, ".busy"},      i, int'(busy),      int'(tbl[i].e_busy));
            chk({tag, ".done"},      i, int'(done),      int'(tbl[i].e_done));
            chk({tag, ".iterIdx"},   i, int'(iterIdx),   int'(tbl[i].e_idx));
            chk({tag, ".noStall"},   i, int'(noStall),   int'(!tbl[i].stall));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
        reset = 1'b0;
        tbl.delete();
    endtask

    task automatic build_basic();
        // progLen=3, numIter=2, no stall
        add(1,0,0, 0,0,0,0,0,0);
        add(0,0,0, 0,0,0,1,0,0);
        add(0,0,0, 1,1,0,1,0,0);
        add(0,0,0, 2,1,0,1,0,0);
        add(0,0,0, 0,1,0,1,0,1);
        add(0,0,0, 1,1,0,1,0,1);
        add(0,0,0, 2,1,0,1,0,1);
        add(0,0,0, 0,1,1,1,0,0);
        add(0,0,0, 0,0,0,0,1,0);
        add(0,0,0, 0,0,0,0,0,0);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        stall   = 1'b0;
        progLen = '0;
        numIter = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rdAddr",    0, int'(rdAddr),    0);
        chk("reset.iterIdx",   0, int'(iterIdx),   0);
        chk("reset.instValid", 0, int'(instValid), 0);
        chk("reset.lastInst",  0, int'(lastInst),  0);
        chk("reset.busy",      0, int'(busy),      0);
        chk("reset.done",      0, int'(done),      0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        cur_prog = 6'd3; cur_iter = 16'd2;
        build_basic();
        run_table("basic");

        // Stall in cycles 3-4; progLen/numIter change after acceptance must be ignored.
        cur_prog = 6'd3; cur_iter = 16'd2;
        add(1,0,0, 0,0,0,0,0,0);
        cur_prog = 6'd7; cur_iter = 16'd9;
        add(0,0,0, 0,0,0,1,0,0);
        add(0,0,0, 1,1,0,1,0,0);
        add(0,1,0, 2,1,0,1,0,0);
        add(0,1,0, 2,1,0,1,0,0);
        add(0,0,0, 2,1,0,1,0,0);
        add(0,0,0, 0,1,0,1,0,1);
        add(0,0,0, 1,1,0,1,0,1);
        add(0,0,0, 2,1,0,1,0,1);
        add(0,0,0, 0,1,1,1,0,0);
        add(0,0,0, 0,0,0,0,1,0);
        add(0,0,0, 0,0,0,0,0,0);
        run_table("stall");

        cur_prog = 6'd0; cur_iter = 16'd2;
        add(1,0,0, 0,0,0,0,0,0);
        add(0,0,0, 0,0,0,0,1,0);
        add(0,0,0, 0,0,0,0,0,0);
        run_table("zero_len");

        cur_prog = 6'd3; cur_iter = 16'd0;
        add(1,0,0, 0,0,0,0,0,0);
        add(0,0,0, 0,0,0,0,1,0);
        add(0,0,0, 0,0,0,0,0,0);
        run_table("zero_iter");

        // Full-depth program: no early wrap at the address width.
        cur_prog = 6'd32; cur_iter = 16'd1;
        add(1,0,0, 0,0,0,0,0,0);
        for (int c = 1; c <= 32; c++) add(0,0,0, c-1, (c >= 2) ? 1 : 0, 0,1,0,0);
        add(0,0,0, 0,1,1,1,0,0);
        add(0,0,0, 0,0,0,0,1,0);
        add(0,0,0, 0,0,0,0,0,0);
        run_table("full_depth");

        // Mid-run start is ignored; reset in cycle 4 clears everything without done.
        cur_prog = 6'd3; cur_iter = 16'd2;
        add(1,0,0, 0,0,0,0,0,0);
        add(0,0,0, 0,0,0,1,0,0);
        add(1,0,0, 1,1,0,1,0,0);
        add(0,0,0, 2,1,0,1,0,0);
        add(0,0,1, 0,1,0,1,0,1);
        for (int c = 5; c <= 8; c++) add(0,0,0, 0,0,0,0,0,0);
        run_table("restart_reset");
        build_basic();
        run_table("after_reset");

        // Stall held through DRAIN for 5 cycles.
        cur_prog = 6'd2; cur_iter = 16'd1;
        add(1,0,0, 0,0,0,0,0,0);
        add(0,0,0, 0,0,0,1,0,0);
        add(0,0,0, 1,1,0,1,0,0);
        for (int c = 3; c <= 7; c++) add(0,1,0, 0,1,1,1,0,0);
        add(0,0,0, 0,1,1,1,0,0);
        add(0,0,0, 0,0,0,0,1,0);
        add(0,0,0, 0,0,0,0,0,0);
        run_table("drain_stall");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
